// File: rtl/dpe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpe_pkg
// Description : Shared DPE types: destination addresses, the packet error
//               flag record, the latched packet header, and keep helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package dpe_pkg;

    typedef logic [3:0] dpe_addr_t;

    localparam dpe_addr_t DPE_ADDR_CPU  = 4'h0;
    localparam dpe_addr_t DPE_ADDR_MAC0 = 4'h1;
    localparam dpe_addr_t DPE_ADDR_MAC1 = 4'h2;
    localparam dpe_addr_t DPE_ADDR_DROP = 4'hF;

    // Sticky per-capture error flags, MSB first: {hdr, len, dst, keep}
    typedef struct packed {
        logic hdr;
        logic len;
        logic dst;
        logic keep;
    } dpe_pkt_err_t;

    // Sideband fields that must stay constant across all beats of a packet
    typedef struct packed {
        dpe_addr_t   src;
        dpe_addr_t   dst;
        logic        bypass_all;
        logic        bypass_stage;
        logic [7:0]  tid;
    } dpe_hdr_t;

    // Number of valid bytes in a 128-bit beat
    function automatic logic [15:0] dpe_popcount16(input logic [15:0] keep);
        logic [15:0] cnt;
        cnt = 16'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {15'd0, keep[i]};
        end
        return cnt;
    endfunction

    // True when keep is non-zero and packed against bit 0 (e.g. 16'h003F)
    function automatic logic dpe_keep_contig(input logic [15:0] keep);
        logic [15:0] plus_one;
        plus_one = keep + 16'd1;
        return (keep != 16'd0) && ((keep & plus_one) == 16'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_if
// Description : Plain AXI-Stream bus (data, keep, valid, ready, last).
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_if #(
    parameter int DATA_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);

endinterface
`default_nettype wire

// File: rtl/dpe_if.sv
`default_nettype none
// ============================================================================
// Module      : dpe_if
// Description : 128-bit DPE stream bus with clock/reset and tuser sideband.
// Revision    : 1.0 - initial release
// ============================================================================
interface dpe_if;
    import dpe_pkg::*;

    logic          clk;
    logic          rst;
    logic [127:0]  tdata;
    logic [15:0]   tkeep;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    dpe_addr_t     tuser_src;
    dpe_addr_t     tuser_dst;
    logic          tuser_bypass_all;
    logic          tuser_bypass_stage;
    logic [7:0]    tid;

    modport s_axis (
        input  clk, rst, tdata, tkeep, tvalid, tlast,
               tuser_src, tuser_dst, tuser_bypass_all, tuser_bypass_stage, tid,
        output tready
    );

    modport m_axis (
        input  clk, rst, tready,
        output tdata, tkeep, tvalid, tlast,
               tuser_src, tuser_dst, tuser_bypass_all, tuser_bypass_stage, tid
    );

endinterface
`default_nettype wire

// File: rtl/pcapwriter.sv
`default_nettype none
// ============================================================================
// Module      : pcapwriter
// Description : Capture sink. Stalls its stream for the header slots it has
//               to emit: two beats for the global file header after reset
//               (only when a file is named) and one beat for the per-record
//               header after every packet.
// Revision    : 1.0 - initial release
// ============================================================================
module pcapwriter #(
    parameter string SIGNAL_TYPE   = "axisif",
    parameter int    DATA_WIDTH    = 128,
    parameter string PCAP_FILENAME = "none"
) (
    input  logic  clk,
    input  logic  rst,
    axis_if.slave s
);

    localparam logic [1:0] c_GLOBAL_HDR_BEATS = (PCAP_FILENAME == "none") ? 2'd0 : 2'd2;

    generate
        if ((SIGNAL_TYPE == "axisif") && (DATA_WIDTH == 128)) begin : g_axisif
            logic [1:0] r_gap;

            // Count down header slots; a record header follows every tlast
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_gap <= c_GLOBAL_HDR_BEATS;
                end else if (s.tvalid && s.tready && s.tlast) begin
                    r_gap <= 2'd1;
                end else if (r_gap != 2'd0) begin
                    r_gap <= r_gap - 2'd1;
                end
            end

            assign s.tready = (r_gap == 2'd0);
        end else begin : g_unsupported
            assign s.tready = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/dpe_pcapwriter.sv
`default_nettype none
// ============================================================================
// Module      : dpe_pcapwriter
// Description : DPE stream checker/capture front end. Tracks packet framing,
//               sideband consistency and length, keeps packet/byte counters,
//               and forwards every accepted beat to the pcapwriter sink.
//               Define DPE_PCAPWRITER_LFSR_EN to add pseudo-random
//               back-pressure on the input.
// Revision    : 1.0 - initial release
// ============================================================================
module dpe_pcapwriter
    import dpe_pkg::*;
#(
    parameter string       PCAP_FILENAME = "none",
    parameter dpe_addr_t   EXP_TUSER_DST = DPE_ADDR_CPU,
    parameter logic [15:0] MAX_PKT_BYTES = 16'd1518,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    dpe_if.s_axis       inp,
    output logic [31:0] pkt_count,
    output logic [31:0] byte_count,
    output logic [15:0] last_len,
    output logic        pkt_done,
    output logic [3:0]  err,
    output logic        busy
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BODY = 1'b1;

    logic [0:0]   r_state;
    dpe_hdr_t     r_hdr;
    dpe_hdr_t     w_hdr;
    logic [15:0]  r_len;
    logic [15:0]  w_beat_bytes;
    logic [15:0]  w_len_base;
    logic [16:0]  w_len_sum;
    logic [15:0]  w_pkt_len;
    dpe_pkt_err_t r_err;
    logic [31:0]  r_pkt_count;
    logic [31:0]  r_byte_count;
    logic [15:0]  r_last_len;
    logic         r_pkt_done;
    logic [1:0]   r_live;
    logic         w_gate;
    logic         w_accept;
    logic         w_first;

    axis_if #(.DATA_WIDTH(128)) u_cap_axis ();

    pcapwriter #(
        .SIGNAL_TYPE   ("axisif"),
        .DATA_WIDTH    (128),
        .PCAP_FILENAME (PCAP_FILENAME)
    ) u_pcapwriter (
        .clk (inp.clk),
        .rst (inp.rst),
        .s   (u_cap_axis)
    );

`ifdef DPE_PCAPWRITER_LFSR_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, stepped every cycle
    always_ff @(posedge inp.clk) begin
        if (inp.rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        end
    end

    assign w_gate = r_lfsr[0];
`else
    assign w_gate = 1'b1;
`endif

    // Ready is built only from flops so it never follows tvalid; r_live keeps
    // it low through reset and the first cycle after it.
    assign inp.tready   = r_live[1] & w_gate & u_cap_axis.tready;
    assign w_accept     = inp.tvalid && inp.tready;
    assign w_first      = (r_state == c_IDLE);
    assign w_hdr        = {inp.tuser_src, inp.tuser_dst, inp.tuser_bypass_all,
                           inp.tuser_bypass_stage, inp.tid};
    assign w_beat_bytes = dpe_popcount16(inp.tkeep);
    assign w_len_base   = w_first ? 16'd0 : r_len;
    assign w_len_sum    = {1'b0, w_len_base} + {1'b0, w_beat_bytes};
    assign w_pkt_len    = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];

    // Sink sees exactly the accepted beats, including errored packets
    assign u_cap_axis.tdata  = inp.tdata;
    assign u_cap_axis.tkeep  = inp.tkeep;
    assign u_cap_axis.tlast  = inp.tlast;
    assign u_cap_axis.tvalid = w_accept;

    // Two-stage ready enable released after reset
    always_ff @(posedge inp.clk) begin
        if (inp.rst) begin
            r_live <= 2'b00;
        end else begin
            r_live <= {r_live[0], 1'b1};
        end
    end

    // Packet framing: IDLE waits for a first beat, BODY runs until tlast
    always_ff @(posedge inp.clk) begin
        if (inp.rst) begin
            r_state <= c_IDLE;
        end else if (w_accept) begin
            r_state <= inp.tlast ? c_IDLE : c_BODY;
        end
    end

    // Header capture on the first beat and saturating running length
    always_ff @(posedge inp.clk) begin
        if (inp.rst) begin
            r_hdr <= '0;
            r_len <= 16'd0;
        end else if (w_accept) begin
            if (w_first) begin
                r_hdr <= w_hdr;
            end
            r_len <= w_pkt_len;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge inp.clk) begin
        if (inp.rst) begin
            r_err <= '0;
        end else if (w_accept) begin
            if (!w_first && (w_hdr != r_hdr)) begin
                r_err.hdr <= 1'b1;
            end
            if (w_first && (inp.tuser_dst != EXP_TUSER_DST)) begin
                r_err.dst <= 1'b1;
            end
            if (inp.tlast ? !dpe_keep_contig(inp.tkeep) : (inp.tkeep != 16'hFFFF)) begin
                r_err.keep <= 1'b1;
            end
            if (inp.tlast && (w_pkt_len > MAX_PKT_BYTES)) begin
                r_err.len <= 1'b1;
            end
        end
    end

    // Counters and completion pulse, visible the cycle after the tlast beat
    always_ff @(posedge inp.clk) begin
        if (inp.rst) begin
            r_pkt_count  <= 32'd0;
            r_byte_count <= 32'd0;
            r_last_len   <= 16'd0;
            r_pkt_done   <= 1'b0;
        end else begin
            r_pkt_done <= w_accept && inp.tlast;
            if (w_accept) begin
                r_byte_count <= r_byte_count + {16'd0, w_beat_bytes};
            end
            if (w_accept && inp.tlast) begin
                r_pkt_count <= r_pkt_count + 32'd1;
                r_last_len  <= w_pkt_len;
            end
        end
    end

    assign pkt_count  = r_pkt_count;
    assign byte_count = r_byte_count;
    assign last_len   = r_last_len;
    assign pkt_done   = r_pkt_done;
    assign err        = r_err;
    assign busy       = (r_state == c_BODY);

endmodule
`default_nettype wire
